// File: rtl/m_seq_checker_pkg.sv
// Shared definitions for the m-sequence checker: FSM states, default LFSR
// parameters (common with the generator) and the bit-prediction function.
package m_seq_checker_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int                    DEFAULT_N    = 8;
    localparam logic [DEFAULT_N-1:0]  DEFAULT_POLY = 8'b10001110;
    localparam int                    PRED_MAX_N   = 32;

    // r[0] is the oldest bit; tap r[i] is enabled by poly[n-1-i].
    function automatic logic lfsr_pred(input logic [PRED_MAX_N-1:0] r,
                                       input logic [PRED_MAX_N-1:0] poly,
                                       input int n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < PRED_MAX_N; i++) begin
            if (i < n) p = p ^ (r[i] & poly[n-1-i]);
        end
        return p;
    endfunction

endpackage

// File: rtl/m_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module m_seq_checker_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/m_seq_checker.sv
// PN m-sequence receive checker: self-synchronises a local LFSR, locks, then
// free-runs and flags every received bit that disagrees with the prediction.
module m_seq_checker
    import m_seq_checker_pkg::*;
#(
    parameter int            N           = DEFAULT_N,
    parameter logic [N-1:0]  POLY        = DEFAULT_POLY,
    parameter int            LOCK_CNT    = 16,
    parameter int            WINDOW      = 64,
    parameter int            LOSS_THRESH = 8,
    parameter int            CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int FILL_W = $clog2(N + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_sr;
    logic [FILL_W-1:0]  r_fill_cnt;
    logic [7:0]         r_match_cnt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [WIN_W-1:0]   r_win_err;
    logic               r_locked;
    logic               r_err_pulse;

    logic               w_pred;
    logic               w_mismatch;
    logic               w_match;
    logic               w_newbit;
    logic               w_bit_inc;
    logic               w_err_inc;
    logic               w_win_done;

    assign w_pred     = lfsr_pred(PRED_MAX_N'(r_sr), PRED_MAX_N'(POLY), N);
    assign w_mismatch = din ^ w_pred;
    // An all-zero register predicts zeros forever, so it must never build lock.
    assign w_match    = ~w_mismatch & (|r_sr);
    assign w_win_done = (r_win_cnt == WIN_W'(WINDOW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SEARCH;
        else        r_state <= w_state_nxt;
    end

    // NOTE: combinational blocks assign a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (din_valid) begin
            unique case (r_state)
                SEARCH: if (r_fill_cnt == FILL_W'(N - 1)) w_state_nxt = VERIFY;
                VERIFY: if (w_match && (r_match_cnt == 8'(LOCK_CNT - 1))) w_state_nxt = LOCKED;
                LOCKED: if (w_mismatch && (r_win_err == WIN_W'(LOSS_THRESH - 1))) w_state_nxt = SEARCH;
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        w_newbit  = din;
        w_bit_inc = 1'b0;
        w_err_inc = 1'b0;
        if (r_state == LOCKED) begin
            w_newbit  = w_pred;
            w_bit_inc = din_valid;
            w_err_inc = din_valid & w_mismatch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr        <= '0;
            r_fill_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err_inc;
            r_locked    <= (w_state_nxt == LOCKED);
            if (din_valid) begin
                r_sr <= {w_newbit, r_sr[N-1:1]};
                unique case (r_state)
                    SEARCH: begin
                        if (w_state_nxt == VERIFY) begin
                            r_fill_cnt  <= '0;
                            r_match_cnt <= '0;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + FILL_W'(1);
                        end
                    end
                    VERIFY: begin
                        r_match_cnt <= w_match ? r_match_cnt + 8'd1 : 8'd0;
                        r_win_cnt   <= '0;
                        r_win_err   <= '0;
                    end
                    LOCKED: begin
                        if (w_state_nxt == SEARCH || w_win_done) begin
                            r_fill_cnt <= '0;
                            r_win_cnt  <= '0;
                            r_win_err  <= '0;
                        end else begin
                            r_win_cnt <= r_win_cnt + WIN_W'(1);
                            r_win_err <= r_win_err + WIN_W'(w_mismatch);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    m_seq_checker_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_err_inc),
        .clr   (clr),
        .cnt   (err_cnt)
    );

    m_seq_checker_sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bit_inc),
        .clr   (clr),
        .cnt   (bit_cnt)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_m_seq_checker.sv
// Bench for m_seq_checker: a default instance and a CNT_W=4 instance share one
// stimulus stream and are compared every cycle against a beat-level model.
module tb_m_seq_checker;

    localparam int         N           = 8;
    localparam logic [7:0] POLY        = 8'b10001110;
    localparam logic [7:0] SEED        = 8'h08;
    localparam int         LOCK_CNT    = 16;
    localparam int         WINDOW      = 64;
    localparam int         LOSS_THRESH = 8;
    localparam int         M_SEARCH    = 0;
    localparam int         M_VERIFY    = 1;
    localparam int         M_LOCKED    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic clr = 1'b0;

    logic        locked0, pulse0, locked1, pulse1;
    logic [15:0] ecnt0, bcnt0;
    logic [3:0]  ecnt1, bcnt1;

    int n_cmp = 0;
    int n_mis = 0;

    m_seq_checker u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr(clr),
        .locked(locked0), .err_pulse(pulse0), .err_cnt(ecnt0), .bit_cnt(bcnt0)
    );

    m_seq_checker #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr(clr),
        .locked(locked1), .err_pulse(pulse1), .err_cnt(ecnt1), .bit_cnt(bcnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: history of accepted bits by beat index
    int  md_mode[2], md_fill[2], md_match[2], md_wn[2], md_we[2], md_k[2];
    bit  md_hist[2][1024];
    bit  ex_locked[2], ex_pulse[2];
    int  ex_err[2], ex_bit[2];

    function automatic int cmax(input int m);
        return (m == 0) ? 65535 : 15;
    endfunction

    task automatic model_reset(input int m);
        md_mode[m] = M_SEARCH; md_fill[m] = 0; md_match[m] = 0;
        md_wn[m] = 0; md_we[m] = 0; md_k[m] = 0;
        for (int i = 0; i < 1024; i++) md_hist[m][i] = 1'b0;
        ex_locked[m] = 1'b0; ex_pulse[m] = 1'b0; ex_err[m] = 0; ex_bit[m] = 0;
    endtask

    task automatic model_beat(input int m, input bit d, input bit v, input bit c);
        bit pred, nz, nb, pulse, e_inc, b_inc;
        int base;
        pulse = 0; e_inc = 0; b_inc = 0;
        if (v) begin
            base = md_k[m] - N;
            pred = 0; nz = 0;
            for (int i = 0; i < N; i++) begin
                pred ^= POLY[N-1-i] & md_hist[m][(base + i) & 1023];
                nz   |= md_hist[m][(base + i) & 1023];
            end
            nb = d;
            case (md_mode[m])
                M_SEARCH: begin
                    md_fill[m]++;
                    if (md_fill[m] == N) begin md_mode[m] = M_VERIFY; md_match[m] = 0; end
                end
                M_VERIFY: begin
                    if (d == pred && nz) begin
                        md_match[m]++;
                        if (md_match[m] == LOCK_CNT) begin
                            md_mode[m] = M_LOCKED; md_wn[m] = 0; md_we[m] = 0;
                        end
                    end else begin
                        md_match[m] = 0;
                    end
                end
                default: begin
                    nb = pred; b_inc = 1; md_wn[m]++;
                    if (d != pred) begin pulse = 1; e_inc = 1; md_we[m]++; end
                    if (md_we[m] == LOSS_THRESH) begin
                        md_mode[m] = M_SEARCH; md_fill[m] = 0;
                    end else if (md_wn[m] == WINDOW) begin
                        md_wn[m] = 0; md_we[m] = 0;
                    end
                end
            endcase
            md_hist[m][md_k[m] & 1023] = nb;
            md_k[m]++;
        end
        if (c) begin
            ex_err[m] = 0; ex_bit[m] = 0;
        end else begin
            if (e_inc && ex_err[m] < cmax(m)) ex_err[m]++;
            if (b_inc && ex_bit[m] < cmax(m)) ex_bit[m]++;
        end
        ex_pulse[m]  = pulse;
        ex_locked[m] = (md_mode[m] == M_LOCKED);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0); model_reset(1);
        end else begin
            model_beat(0, din, din_valid, clr);
            model_beat(1, din, din_valid, clr);
        end
    end

    always @(negedge clk) begin
        check("dut0 locked",    locked0, ex_locked[0]);
        check("dut0 err_pulse", pulse0,  ex_pulse[0]);
        check("dut0 err_cnt",   ecnt0,   ex_err[0]);
        check("dut0 bit_cnt",   bcnt0,   ex_bit[0]);
        check("dut4 locked",    locked1, ex_locked[1]);
        check("dut4 err_pulse", pulse1,  ex_pulse[1]);
        check("dut4 err_cnt",   ecnt1,   ex_err[1]);
        check("dut4 bit_cnt",   bcnt1,   ex_bit[1]);
    end

    // ---------------- generator: s[k+8] = XOR POLY[7-i] & s[k+i]
    bit gq[$];

    task automatic gen_seed();
        gq.delete();
        for (int i = 0; i < N; i++) gq.push_back(SEED[i]);
    endtask

    task automatic gen_next(output bit b);
        bit f;
        f = 0;
        for (int i = 0; i < N; i++) f ^= POLY[N-1-i] & gq[i];
        b = gq[0];
        gq.push_back(f);
        void'(gq.pop_front());
    endtask

    task automatic beat_raw(input bit v, input bit d, input bit c);
        din = d; din_valid = v; clr = c;
        @(posedge clk); #1;
        din_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic beat_gen(input bit inv, input bit c);
        bit g;
        gen_next(g);
        beat_raw(1'b1, g ^ inv, c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst locked0", locked0, 0); check("rst pulse0", pulse0, 0);
        check("rst ecnt0", ecnt0, 0);     check("rst bcnt0", bcnt0, 0);
        check("rst locked1", locked1, 0); check("rst ecnt1", ecnt1, 0);
        check("rst bcnt1", bcnt1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        gen_seed();
    endtask

    initial begin
        int nv, cyc, nb;
        bit v;
        gen_seed();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: clean stream locks after beat 24; 100 locked beats counted
        for (int b = 1; b <= 24; b++) begin
            beat_gen(0, 0);
            if (b == 23) check("t1 not locked at 23", locked0, 0);
            if (b == 24) check("t1 locked at 24", locked0, 1);
        end
        for (int b = 0; b < 100; b++) beat_gen(0, 0);
        check("t1 bit_cnt", bcnt0, 100);
        check("t1 err_cnt", ecnt0, 0);
        check("t1 bit_cnt sat4", bcnt1, 15);

        // 2: single inverted bit (locked beats 101..110, error at 105)
        for (int b = 0; b < 10; b++) begin
            beat_gen(b == 4, 0);
            if (b == 4) check("t2 pulse", pulse0, 1);
            if (b == 5) check("t2 pulse gone", pulse0, 0);
        end
        check("t2 err_cnt", ecnt0, 1);
        check("t2 locked", locked0, 1);

        // 3: pad to window boundary (beat 128 carries clr), then 8 errors in 22 beats
        for (int b = 111; b <= 128; b++) beat_gen(0, b == 128);
        for (int j = 0; j < 8; j++) begin
            beat_gen(1, 0);
            if (j == 6) check("t3 still locked", locked0, 1);
            if (j < 7) begin beat_gen(0, 0); beat_gen(0, 0); end
        end
        check("t3 unlocked", locked0, 0);
        check("t3 err_cnt", ecnt0, 8);
        check("t3 bit_cnt", bcnt0, 22);
        for (int b = 1; b <= 24; b++) begin
            beat_gen(0, 0);
            if (b == 23) check("t3 relock not yet", locked0, 0);
            if (b == 24) check("t3 relock", locked0, 1);
        end

        // 4: random 50% valid, lock after 24 valid beats
        do_reset();
        nv = 0; cyc = 0;
        while (nv < 24 && cyc < 2000) begin
            cyc++;
            if ($urandom_range(0, 1) == 1) begin
                beat_gen(0, 0);
                nv++;
                if (nv == 23) check("t4 not locked at 23", locked0, 0);
                if (nv == 24) check("t4 locked at 24", locked0, 1);
            end else begin
                beat_raw(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        if (nv < 24) check("t4 timeout valid beats", nv, 24);
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 1) == 1) begin beat_gen(0, 0); nb++; end
            else beat_raw(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("t4 bit_cnt", bcnt0, nb);
        check("t4 bit_cnt4", bcnt1, (nb > 15) ? 15 : nb);

        // random valid / error / clr mix, model-checked every cycle
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) beat_gen(($urandom_range(0, 39) == 0), ($urandom_range(0, 49) == 0));
            else   beat_raw(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end

        // 5: all-zero input never locks
        do_reset();
        for (int b = 1; b <= 500; b++) begin
            beat_raw(1'b1, 1'b0, 1'b0);
            if (b % 100 == 0) check("t5 never locked", locked0, 0);
        end

        // 6: reset mid-lock, clr on an error beat, err_cnt saturation at 15
        do_reset();
        for (int b = 0; b < 30; b++) beat_gen(0, 0);
        beat_gen(1, 0); beat_gen(1, 0);
        check("t6 pre-reset err_cnt", ecnt1, 2);
        do_reset();
        for (int b = 0; b < 24; b++) beat_gen(0, 0);
        check("t6 relocked", locked1, 1);
        beat_gen(1, 1);
        check("t6 clr pulse", pulse1, 1);
        check("t6 clr err_cnt", ecnt1, 0);
        check("t6 clr bit_cnt", bcnt1, 0);
        check("t6 clr err_cnt0", ecnt0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 8; b++) beat_gen(1, 0);
            check("t6 lost lock", locked1, 0);
            if (r < 2) begin
                for (int b = 0; b < 32; b++) beat_gen(0, 0);
                check("t6 relock round", locked1, 1);
            end
        end
        check("t6 err_cnt saturated", ecnt1, 15);
        for (int b = 0; b < 32; b++) beat_gen(1, 0);
        check("t6 err_cnt held", ecnt1, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
